// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: bus widths, bus layouts and access FSM encoding.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 105;
    localparam int MEM_WB_W  = 70;

    // Field order is MSB first, matching the execute-stage packer.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rt_value;
        logic [31:0] alu_out;
        logic        mem_to_reg;
        logic        reg_w_en;
        logic        dm_r_en;
        logic        dm_w_en;
    } exe_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        reg_w_en;
    } mem_wb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller: request/stall generation and load-data capture
// for accesses that complete while the stage is externally held.
module mem_access_fsm
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        access,
    input  logic        bubble,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        mem_stall,
    output logic [31:0] load_data
);

    mem_state_e  state_r;
    mem_state_e  state_nxt_s;
    logic [31:0] rdata_buf_r;
    logic        latch_s;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load data buffer, filled when an access completes under an external hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_buf_r <= 32'h0000_0000;
        end else if (latch_s) begin
            rdata_buf_r <= dm_rdata;
        end else begin
            rdata_buf_r <= rdata_buf_r;
        end
    end

    // Next-state, request and stall decode; dm_req depends on state only, never on dm_ack
    always_comb begin
        state_nxt_s = state_r;
        dm_req      = 1'b0;
        mem_stall   = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                dm_req = access;
                if (access && dm_ack) begin
                    if (bubble) begin
                        state_nxt_s = HELD;
                        latch_s     = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (access) begin
                    state_nxt_s = WAIT;
                    mem_stall   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                dm_req    = 1'b1;
                mem_stall = !dm_ack;
                if (dm_ack) begin
                    if (bubble) begin
                        state_nxt_s = HELD;
                        latch_s     = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HELD: begin
                if (!bubble) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Load data source: live memory data unless it was captured during a hold
    always_comb begin
        load_data = dm_rdata;
        if (state_r == HELD) begin
            load_data = rdata_buf_r;
        end else begin
            load_data = dm_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: execute-to-memory stage register, data-memory interface,
// writeback result selection and hazard-unit forwarding/stall outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BUS_IN_W  = EXE_MEM_W,
    parameter int BUS_OUT_W = MEM_WB_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flushM,
    input  logic                 bubbleM,
    input  logic [BUS_IN_W-1:0]  exe_to_mem_bus,
    output logic [BUS_OUT_W-1:0] mem_to_wb_bus,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [ADDR_W-1:0]    dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata,
    output logic                 mem_stall,
    output logic [31:0]          mem_result,
    output logic [4:0]           rd_mem,
    output logic                 reg_w_en_mem,
    output logic [31:0]          debug_pc
);

    exe_mem_t    stage_r;
    logic        flush_pend_r;
    logic        adv_s;
    logic        access_s;
    logic [31:0] load_data_s;
    logic [31:0] result_s;
    mem_wb_t     wb_s;

    assign adv_s    = !mem_stall && !bubbleM;
    assign access_s = stage_r.dm_r_en | stage_r.dm_w_en;

    // Stage register: advances only when no access is outstanding and no external hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_r <= '0;
        end else if (adv_s) begin
            if (flushM || flush_pend_r) begin
                stage_r <= '0;
            end else begin
                stage_r <= exe_mem_t'(exe_to_mem_bus);
            end
        end else begin
            stage_r <= stage_r;
        end
    end

    // A flush seen mid-access is remembered so the access can finish first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_pend_r <= 1'b0;
        end else if (adv_s) begin
            flush_pend_r <= 1'b0;
        end else if (flushM && mem_stall) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    mem_access_fsm u_fsm (
        .clk       (clk),
        .rstn      (rstn),
        .access    (access_s),
        .bubble    (bubbleM),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .dm_req    (dm_req),
        .mem_stall (mem_stall),
        .load_data (load_data_s)
    );

    // Writeback value select
    always_comb begin
        result_s = stage_r.alu_out;
        if (stage_r.mem_to_reg) begin
            result_s = load_data_s;
        end else begin
            result_s = stage_r.alu_out;
        end
    end

    // Both enables set counts as a store
    assign dm_we    = stage_r.dm_w_en;
    assign dm_addr  = stage_r.alu_out[ADDR_W+1:2];
    assign dm_wdata = stage_r.rt_value;

    assign wb_s.pc       = stage_r.pc;
    assign wb_s.rd       = stage_r.rd;
    assign wb_s.result   = result_s;
    assign wb_s.reg_w_en = stage_r.reg_w_en & ~mem_stall;
    assign mem_to_wb_bus = wb_s;

    assign mem_result   = result_s;
    assign rd_mem       = stage_r.rd;
    assign reg_w_en_mem = stage_r.reg_w_en;
    assign debug_pc     = stage_r.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         flushM = 1'b0;
    logic         bubbleM = 1'b0;
    logic [104:0] exe_to_mem_bus = '0;
    logic [69:0]  mem_to_wb_bus;
    logic         dm_req;
    logic         dm_we;
    logic [7:0]   dm_addr;
    logic [31:0]  dm_wdata;
    logic         dm_ack = 1'b0;
    logic [31:0]  dm_rdata = 32'h0;
    logic         mem_stall;
    logic [31:0]  mem_result;
    logic [4:0]   rd_mem;
    logic         reg_w_en_mem;
    logic [31:0]  debug_pc;

    int checks = 0;
    int errors = 0;

    // Model: the instruction held in MEM, whether its access already finished, captured data
    logic [104:0] m_in = '0;
    bit           m_served = 1'b0;
    logic [31:0]  m_buf = 32'h0;
    bit           m_pend = 1'b0;

    int nreq, nstall, nbad;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(8), .BUS_IN_W(105), .BUS_OUT_W(70)) dut (
        .clk(clk), .rstn(rstn), .flushM(flushM), .bubbleM(bubbleM),
        .exe_to_mem_bus(exe_to_mem_bus), .mem_to_wb_bus(mem_to_wb_bus),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
        .mem_result(mem_result), .rd_mem(rd_mem), .reg_w_en_mem(reg_w_en_mem),
        .debug_pc(debug_pc)
    );

    function automatic logic [104:0] mk(input logic [31:0] pc, input logic [4:0] rd,
                                        input logic [31:0] rt, input logic [31:0] alu,
                                        input logic m2r, input logic rwe,
                                        input logic ren, input logic wen);
        return {pc, rd, rt, alu, m2r, rwe, ren, wen};
    endfunction

    task automatic chk(input string tag, input logic [104:0] obs, input logic [104:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict(output logic e_req, output logic e_stall, output logic [31:0] e_res);
        logic acc;
        acc     = m_in[1] | m_in[0];
        e_req   = acc && !m_served;
        e_stall = e_req && !dm_ack;
        e_res   = m_in[3] ? (m_served ? m_buf : dm_rdata) : m_in[35:4];
    endtask

    task automatic settle();
        logic e_req, e_stall;
        logic [31:0] e_res;
        @(negedge clk);
        predict(e_req, e_stall, e_res);
        chk("dm_req", dm_req, e_req);
        chk("mem_stall", mem_stall, e_stall);
        chk("mem_result", mem_result, e_res);
        chk("wb_bus", mem_to_wb_bus, {m_in[104:73], m_in[72:68], e_res, m_in[2] & !e_stall});
        chk("dm_we", dm_we, m_in[0]);
        chk("dm_addr", dm_addr, m_in[13:6]);
        chk("dm_wdata", dm_wdata, m_in[67:36]);
        chk("rd_mem", rd_mem, m_in[72:68]);
        chk("reg_w_en_mem", reg_w_en_mem, m_in[2]);
        chk("debug_pc", debug_pc, m_in[104:73]);
    endtask

    task automatic advance();
        logic e_req, e_stall;
        logic [31:0] e_res;
        predict(e_req, e_stall, e_res);
        @(posedge clk);
        if (!rstn) begin
            m_in = '0; m_served = 1'b0; m_pend = 1'b0;
        end else if (!e_stall && !bubbleM) begin
            m_in = (flushM || m_pend) ? '0 : exe_to_mem_bus;
            m_served = 1'b0;
            m_pend = 1'b0;
        end else begin
            if (e_req && dm_ack) begin
                m_served = 1'b1;
                m_buf = dm_rdata;
            end
            if (flushM && e_stall) m_pend = 1'b1;
        end
        #1;
    endtask

    initial begin
        // Reset state
        settle();
        chk("reset_bus", mem_to_wb_bus, 70'h0);
        chk("reset_req", dm_req, 1'b0);
        advance();
        rstn = 1'b1;

        // Plain ALU op
        exe_to_mem_bus = mk(32'h100, 5'd3, 32'h0, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        settle(); advance();
        exe_to_mem_bus = '0;
        settle();
        chk("alu_result", mem_to_wb_bus[32:1], 32'h1234);
        chk("alu_req", dm_req, 1'b0);
        chk("alu_stall", mem_stall, 1'b0);
        advance();

        // Load, memory acks immediately
        exe_to_mem_bus = mk(32'h104, 5'd4, 32'h0, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
        dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
        settle(); advance();
        exe_to_mem_bus = '0;
        settle();
        chk("ld_addr", dm_addr, 8'd4);
        chk("ld_req", dm_req, 1'b1);
        chk("ld_stall", mem_stall, 1'b0);
        chk("ld_result", mem_to_wb_bus[32:1], 32'hCAFE_F00D);
        advance();
        settle();
        chk("ld_req_done", dm_req, 1'b0);
        advance();
        dm_ack = 1'b0;

        // Store acked after 3 wait cycles
        exe_to_mem_bus = mk(32'h108, 5'd5, 32'hA5A5_A5A5, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1);
        settle(); advance();
        exe_to_mem_bus = mk(32'h10C, 5'd6, 32'h0, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        nreq = 0; nstall = 0; nbad = 0;
        for (int k = 0; k < 4; k++) begin
            dm_ack = (k == 3);
            settle();
            if (dm_req && dm_we && dm_addr == 8'd8 && dm_wdata == 32'hA5A5_A5A5) nreq++;
            if (mem_stall) nstall++;
            if (mem_stall && mem_to_wb_bus[0]) nbad++;
            advance();
        end
        chk("st_req_cycles", 32'(nreq), 32'd4);
        chk("st_stall_cycles", 32'(nstall), 32'd3);
        chk("st_wb_gated", 32'(nbad), 32'd0);
        dm_ack = 1'b0;
        exe_to_mem_bus = '0;
        settle(); advance();

        // Load completing under a 2-cycle hold
        exe_to_mem_bus = mk(32'h110, 5'd7, 32'h0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        settle(); advance();
        exe_to_mem_bus = '0;
        nreq = 0;
        bubbleM = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        settle(); if (dm_req) nreq++; advance();
        dm_ack = 1'b0; dm_rdata = 32'hDEAD_BEEF;
        settle(); if (dm_req) nreq++;
        chk("held_result", mem_result, 32'h1111_2222);
        advance();
        bubbleM = 1'b0;
        settle(); if (dm_req) nreq++;
        chk("held_result2", mem_to_wb_bus[32:1], 32'h1111_2222);
        advance();
        chk("held_req_count", 32'(nreq), 32'd1);

        // Flush pulsed while waiting on memory
        exe_to_mem_bus = mk(32'h114, 5'd8, 32'h0, 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
        settle(); advance();
        exe_to_mem_bus = mk(32'h500, 5'd9, 32'h0, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        flushM = 1'b1;
        settle(); advance();
        flushM = 1'b0;
        settle(); advance();
        dm_ack = 1'b1;
        settle(); advance();
        dm_ack = 1'b0;
        settle();
        chk("flush_pc", debug_pc, 32'h0);
        chk("flush_bus", mem_to_wb_bus, 70'h0);
        advance();
        settle();
        chk("after_flush_pc", debug_pc, 32'h500);
        advance();
        exe_to_mem_bus = '0;

        // Reset while waiting on memory
        exe_to_mem_bus = mk(32'h118, 5'd10, 32'h0, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0);
        settle(); advance();
        exe_to_mem_bus = '0;
        settle();
        rstn = 1'b0;
        #1;
        m_in = '0; m_served = 1'b0; m_pend = 1'b0;
        chk("rst_req", dm_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_bus", mem_to_wb_bus, 70'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exe_to_mem_bus = mk(32'h11C, 5'd11, 32'h0, 32'h0C, 1'b1, 1'b1, 1'b1, 1'b0);
        dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
        settle(); advance();
        exe_to_mem_bus = '0;
        settle();
        chk("post_rst_result", mem_result, 32'h1234_5678);
        chk("post_rst_req", dm_req, 1'b1);
        advance();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            exe_to_mem_bus = mk($urandom, 5'($urandom), $urandom, $urandom,
                                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            flushM   = ($urandom_range(0, 9) == 0);
            bubbleM  = ($urandom_range(0, 3) == 0);
            dm_ack   = ($urandom_range(0, 2) != 0);
            dm_rdata = $urandom;
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
